// File: rtl/a0_trace_fifo.sv
// Watches the CPU a0 register and queues each new value with its capture cycle.
// The consumer drains the queue over valid/ready; the CPU is never stalled.
module a0_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [31:0]              a0,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     PTR_ONE = 1;
  localparam logic [TS_W-1:0] TS_ONE  = 1;

  typedef struct packed {
    logic [31:0]     data;
    logic [TS_W-1:0] ts;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW:0]     wptr, rptr;
  logic [31:0]     prev_a0;
  logic [TS_W-1:0] ts;
  logic            chg, full, empty, pop, push, drop;
  entry_t          head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign chg  = en && (a0 != prev_a0);
  assign pop  = !empty && out_ready;
  assign push = chg && (!full || pop);
  assign drop = chg && full && !pop;

  assign head      = mem[rptr[AW-1:0]];
  assign out_valid = !empty;
  assign out_data  = head.data;
  assign out_ts    = head.ts;
  assign count     = wptr - rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a0  <= '0;
      ts       <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (en) begin
        prev_a0 <= a0;
        ts      <= ts + TS_ONE;
      end
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      // prev_a0 still tracks a dropped value so it is not re-captured later.
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Storage needs no reset: entries are only visible once the pointers advance.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= '{data: a0, ts: ts};
  end

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Randomised and directed stimulus against a queue-based reference model.
// A second instance with TS_W=4 exercises timestamp wrap-around.
module tb_a0_trace_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, en, out_ready;
  logic [31:0] a0;

  logic        v16, v4, ovf16, ovf4;
  logic [31:0] d16, d4;
  logic [15:0] ts16;
  logic [3:0]  ts4;
  logic [4:0]  cnt16, cnt4;
  logic [7:0]  drp16, drp4;

  always #5 clk = ~clk;

  a0_trace_fifo #(.DEPTH(DEPTH), .TS_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .a0(a0),
    .out_valid(v16), .out_ready(out_ready), .out_data(d16), .out_ts(ts16),
    .count(cnt16), .overflow(ovf16), .drop_cnt(drp16));

  a0_trace_fifo #(.DEPTH(DEPTH), .TS_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .a0(a0),
    .out_valid(v4), .out_ready(out_ready), .out_data(d4), .out_ts(ts4),
    .count(cnt4), .overflow(ovf4), .drop_cnt(drp4));

  typedef struct {
    logic [31:0] d;
    int unsigned t;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_prev;
  int unsigned m_ts;
  logic        m_ovf;
  int          m_drop;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_model();
    int unsigned t;
    chk("valid16", 64'(v16), 64'(q.size() != 0));
    chk("valid4", 64'(v4), 64'(q.size() != 0));
    chk("count16", 64'(cnt16), 64'(q.size()));
    chk("count4", 64'(cnt4), 64'(q.size()));
    chk("ovf16", 64'(ovf16), 64'(m_ovf));
    chk("ovf4", 64'(ovf4), 64'(m_ovf));
    chk("drop16", 64'(drp16), 64'(m_drop));
    chk("drop4", 64'(drp4), 64'(m_drop));
    if (q.size() != 0) begin
      t = q[0].t;
      chk("data16", 64'(d16), 64'(q[0].d));
      chk("data4", 64'(d4), 64'(q[0].d));
      chk("ts16", 64'(ts16), 64'(t % 65536));
      chk("ts4", 64'(ts4), 64'(t % 16));
    end
  endtask

  // One clock: compare current state, apply inputs, advance model, take the edge.
  task automatic cycle(input logic r, input logic e, input logic [31:0] a, input logic rdy);
    bit pop, chg, full;
    ent_t ne;
    @(negedge clk);
    cmp_model();
    rst = r; en = e; a0 = a; out_ready = rdy;
    if (r) begin
      q.delete(); m_prev = 0; m_ts = 0; m_ovf = 0; m_drop = 0;
    end else begin
      full = (q.size() == DEPTH);
      pop  = (q.size() != 0) && rdy;
      chg  = e && (a != m_prev);
      if (pop) void'(q.pop_front());
      if (chg) begin
        if (!full || pop) begin
          ne.d = a; ne.t = m_ts;
          q.push_back(ne);
        end else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (e) begin
        m_prev = a;
        m_ts++;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    rst = 1; en = 0; a0 = 0; out_ready = 0;
    q.delete(); m_prev = 0; m_ts = 0; m_ovf = 0; m_drop = 0;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);

    // Constant zero after reset never captures.
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);
    #1;
    chk("zero_valid", 64'(v16), 64'd0);
    chk("zero_count", 64'(cnt16), 64'd0);
    chk("zero_ovf", 64'(ovf16), 64'd0);

    // Two changes at cycles 3 and 7, then drain.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, (i < 3) ? 32'd0 : (i < 7) ? 32'd5 : 32'd9, 0);
    #1;
    chk("two_count", 64'(cnt16), 64'd2);
    chk("two_head", 64'(d16), 64'd5);
    chk("two_ts", 64'(ts16), 64'd3);
    cycle(0, 1, 9, 1);
    #1;
    chk("two_second", 64'(d16), 64'd9);
    chk("two_second_ts", 64'(ts16), 64'd7);
    cycle(0, 1, 9, 1);
    #1;
    chk("two_empty", 64'(v16), 64'd0);

    // Twenty changes into a 16-deep FIFO: four drops.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 32'(i + 1), 0);
    #1;
    chk("fill_count", 64'(cnt16), 64'd16);
    chk("fill_ovf", 64'(ovf16), 64'd1);
    chk("fill_drop", 64'(drp16), 64'd4);
    // Full with simultaneous pop and change: push accepted.
    cycle(0, 1, 32'd100, 1);
    #1;
    chk("fullpp_count", 64'(cnt16), 64'd16);
    chk("fullpp_drop", 64'(drp16), 64'd4);
    chk("fullpp_head", 64'(d16), 64'd2);
    for (int i = 0; i < 18; i++) cycle(0, 1, 32'd100, 1);

    // Enable gap: no capture, timestamp holds, draining unaffected.
    cycle(0, 1, 32'd7, 0);
    cycle(0, 1, 32'd8, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 32'(200 + i), i[0]);
    cycle(0, 1, 32'd300, 0);
    cycle(0, 1, 32'd300, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'd300, 1);

    // Drop counter saturation, then reset with three entries queued.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) cycle(0, 1, 32'(1000 + i), 0);
    #1;
    chk("sat_drop", 64'(drp16), 64'd255);
    for (int i = 0; i < 13; i++) cycle(0, 1, 32'd1299, 1);
    #1;
    chk("pre_rst_count", 64'(cnt16), 64'd3);
    cycle(1, 1, 32'd5, 1);
    #1;
    chk("rst_count", 64'(cnt16), 64'd0);
    chk("rst_valid", 64'(v16), 64'd0);
    chk("rst_ovf", 64'(ovf16), 64'd0);
    chk("rst_drop", 64'(drp16), 64'd0);

    // Timestamp wrap on the 4-bit instance.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) cycle(0, 1, 0, 0);
    cycle(0, 1, 32'd7, 0);
    #1;
    chk("wrap_ts4", 64'(ts4), 64'd1);
    chk("wrap_ts16", 64'(ts16), 64'd17);

    // Random traffic.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) < 85),
            32'($urandom_range(0, 3)), ($urandom_range(0, 99) < 45));
    end
    @(negedge clk);
    cmp_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
